// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyzer FSM states, default polynomial/seed, counter width.
package bist_pkg;
  localparam int CNT_W = 16;
  localparam int DEF_WIDTH = 5;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 5'b10100;  // x^5 + x^3 + 1
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = 5'b00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;
endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: left shift with polynomial feedback into bit 0.
module misr_core
  import bist_pkg::*;
#(
  parameter int                WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = DEF_TAPS,
  parameter logic [WIDTH-1:0]  SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] nxt;

  // Next signature: feedback parity into bit 0, shift the rest up, fold in the response.
  always_comb begin
    nxt    = '0;
    nxt[0] = (^(sig & TAPS)) ^ d[0];
    for (int i = 1; i < WIDTH; i++) begin
      nxt[i] = sig[i-1] ^ d[i];
    end
  end

  // Signature register; load has priority so a session restart always begins at SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= nxt;
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST output response analyzer: session FSM, response counter and golden compare around a MISR.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int                WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS         = DEF_TAPS,
  parameter logic [WIDTH-1:0]  SEED         = DEF_SEED,
  parameter int                NUM_PATTERNS = 31,
  parameter logic [WIDTH-1:0]  GOLDEN_SIG   = 5'h10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pattern_cnt
);

  state_t           state, state_n;
  logic             load, absorb, pass_r;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(NUM_PATTERNS - 1));

  misr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (absorb),
    .d     (resp_data),
    .sig   (signature)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and control: start only honoured when idle or done, responses only in RUN.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    absorb  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (resp_valid) begin
          absorb = 1'b1;
          if (last) state_n = S_COMPARE;
        end
      end
      S_COMPARE: state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Response counter and registered verdict; both cleared on session start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pass_r <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      pass_r <= 1'b0;
    end else begin
      if (absorb)              cnt    <= cnt + 1'b1;
      if (state == S_COMPARE)  pass_r <= (signature == GOLDEN_SIG);
    end
  end

  assign busy        = (state == S_RUN) || (state == S_COMPARE);
  assign done        = (state == S_DONE);
  assign pass        = done && pass_r;
  assign pattern_cnt = cnt;

endmodule

// File: doc/bist_misr_analyzer.md
# bist_misr_analyzer

Output response analyzer closing the BIST loop opposite the bit-swapping LFSR pattern generator. It compacts the circuit-under-test responses into a signature using a multiple-input signature register (MISR) built on the same primitive polynomial as the generator. Over a session of NUM_PATTERNS valid responses it accumulates the signature, compares it against a golden value, and reports done/pass to the test controller.

## Interface
- WIDTH, 5: response and signature width.
- TAPS, 5'b10100: feedback tap mask (bit i set means sig[i] feeds bit 0); default is x^5+x^3+1, matching the generator.
- SEED, 5'b00000: signature value loaded at session start.
- NUM_PATTERNS, 31: valid responses per session; legal range 1..2^16-1.
- GOLDEN_SIG, 5'h10: expected final signature.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle session request; honoured only in IDLE or DONE.
- resp_valid  in  1  resp_data is a CUT response to compact this cycle.
- resp_data  in  WIDTH  CUT response word.
- busy  out  1  high in RUN and COMPARE.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  signature == GOLDEN_SIG; meaningful only while done=1; 0 otherwise.
- signature  out  WIDTH  live MISR contents.
- pattern_cnt  out  16  responses absorbed in the current session.

## Operation
- States: IDLE, RUN, COMPARE, DONE.
- IDLE: sig=SEED, cnt=0. start -> RUN (sig<=SEED, cnt<=0).
- RUN: on resp_valid, sig <= next(sig, resp_data) and cnt <= cnt+1. If resp_valid and cnt==NUM_PATTERNS-1 -> COMPARE. resp_valid low: hold sig and cnt; gaps have no effect on the result.
- MISR update: next[0] = (^(sig & TAPS)) ^ d[0]; next[i] = sig[i-1] ^ d[i] for i=1..WIDTH-1. This is the left shift used by the generator.
- COMPARE: register pass_r <= (sig == GOLDEN_SIG) -> DONE. resp_valid is ignored.
- DONE: done=1, pass=pass_r, and sig/cnt frozen. start -> RUN (reloads SEED and clears cnt and pass_r).
- start in RUN or COMPARE is ignored. resp_valid outside RUN is ignored.
- Reset (any time, including mid-session): state=IDLE, sig=SEED, cnt=0, busy=0, done=0, pass=0. Takes effect immediately and asynchronously; release is synchronous to clk.
- cnt is 16 bits and never wraps within a legal session.

## Timing
- start sampled at edge t -> busy=1 after t. The first response is absorbable at edge t+1.
- Each absorbed response updates signature and pattern_cnt on the same edge.
- Last response absorbed at edge k -> COMPARE after k -> DONE after k+1. done and pass are valid two cycles after the last response.
- start in DONE at edge t -> done=0, pass=0, busy=1 after t.

## Structure
- Package bist_pkg holds the state enum, the default WIDTH/TAPS/SEED constants shared with the LFSR generator, and the counter width (16).
- Sub-module misr_core contains the signature register with load (SEED) and enable inputs, and performs the polynomial update. The FSM, counter and comparator live in bist_misr_analyzer.

## Test plan
- Reset, then start, then 31 responses of 5'h00 -> signature 5'h00, done=1, pass=0 (golden 5'h10).
- Start, first response 5'h01, then 30 responses of 5'h00 -> signature 5'h10, pattern_cnt 31, pass=1 exactly two cycles after the last valid.
- Repeat the previous case with random resp_valid gaps -> identical signature 5'h10 and pass=1. Flip bit 2 of any one response -> pass=0.
- Pulse start in RUN after 10 responses -> ignored; pattern_cnt continues to 31 and done is asserted once.
- Assert rst_n low after 15 responses -> immediate IDLE: signature 5'h00, busy/done/pass=0. A new session then completes normally.
- From DONE with pass=1, pulse start -> done and pass drop the next cycle, signature reloads SEED, and a second identical session again yields pass=1.
